// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage between EX/MEM and write-back.
// Drives a req/ack data bus for loads and stores. It steers store bytes onto
// the correct lanes and extracts and extends load data. It detects misaligned
// or illegal-width accesses and requests a pipeline stall while a bus access
// is outstanding.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall_req,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_pc,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_exc
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            drop_q, drop_d;
    logic            dmem_req_q, dmem_req_d;
    logic            dmem_we_q, dmem_we_d;
    logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]      dmem_be_q, dmem_be_d;
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_pc_q, wb_pc_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_reg_write_q, wb_reg_write_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            wb_exc_q, wb_exc_d;

    logic            is_access;
    logic            illegal;
    logic            misaligned;
    logic            access_exc;
    logic            start;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_be;
    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_data;
    logic            drop_now;

    // Classify the instruction in EX/MEM: aligned bus access, faulting access, or neither.
    always_comb begin
        is_access  = ex_valid & (ex_mem_read | ex_mem_write) & ~flush;
        illegal    = (ex_funct3 == 3'b011) | (ex_funct3[2:1] == 2'b11)
                   | (ex_mem_read & ex_mem_write);
        case (ex_funct3[1:0])
            2'b01:   misaligned = ex_alu_result[0];
            2'b10:   misaligned = |ex_alu_result[1:0];
            default: misaligned = 1'b0;
        endcase
        access_exc = is_access & (illegal | misaligned);
        start      = is_access & ~(illegal | misaligned);
    end

    // Replicate store data across lanes and pick the byte enables for the access width.
    always_comb begin
        case (ex_funct3[1:0])
            2'b00: begin
                st_wdata = {4{ex_store_data[7:0]}};
                st_be    = 4'b0001 << ex_alu_result[1:0];
            end
            2'b01: begin
                st_wdata = {2{ex_store_data[15:0]}};
                st_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = ex_store_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    // Shift the addressed byte/half down to bit 0 and extend it to a full word.
    always_comb begin
        ld_shifted = dmem_rdata >> {ex_alu_result[1:0], 3'b000};
        case (ex_funct3)
            3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b100:  ld_data = {24'd0, ld_shifted[7:0]};
            3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b101:  ld_data = {16'd0, ld_shifted[15:0]};
            default: ld_data = dmem_rdata;
        endcase
    end

    // Next-state, bus-request and MEM/WB logic; unloaded cycles leave a bubble in MEM/WB.
    always_comb begin
        state_d        = state_q;
        drop_d         = drop_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        dmem_be_d      = dmem_be_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_exc_d       = 1'b0;
        wb_pc_d        = wb_pc_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        drop_now       = drop_q | flush;
        stall_req      = 1'b0;

        case (state_q)
            IDLE: begin
                drop_d       = 1'b0;
                dmem_req_d   = 1'b0;
                dmem_we_d    = 1'b0;
                dmem_addr_d  = '0;
                dmem_wdata_d = '0;
                dmem_be_d    = 4'b0000;
                stall_req    = start;
                if (start) begin
                    state_d      = BUSY;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = ex_mem_write;
                    dmem_addr_d  = {ex_alu_result[XLEN-1:2], 2'b00};
                    dmem_wdata_d = ex_mem_write ? st_wdata : '0;
                    dmem_be_d    = ex_mem_write ? st_be : 4'b0000;
                end else if (access_exc) begin
                    wb_valid_d = 1'b1;
                    wb_exc_d   = 1'b1;
                    wb_pc_d    = ex_pc;
                    wb_rd_d    = ex_rd;
                    wb_data_d  = ex_alu_result;
                end else if (ex_valid && !flush) begin
                    wb_valid_d     = 1'b1;
                    wb_pc_d        = ex_pc;
                    wb_rd_d        = ex_rd;
                    wb_reg_write_d = ex_reg_write;
                    wb_data_d      = ex_alu_result;
                end
            end
            BUSY: begin
                stall_req = ~dmem_ack;
                if (dmem_ack) begin
                    state_d      = IDLE;
                    drop_d       = 1'b0;
                    dmem_req_d   = 1'b0;
                    dmem_we_d    = 1'b0;
                    dmem_addr_d  = '0;
                    dmem_wdata_d = '0;
                    dmem_be_d    = 4'b0000;
                    if (!drop_now) begin
                        wb_valid_d     = 1'b1;
                        wb_pc_d        = ex_pc;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = ex_mem_read & ex_reg_write;
                        wb_data_d      = ex_mem_read ? ld_data : ex_alu_result;
                    end
                end else begin
                    drop_d = drop_now;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            stall_req = 1'b0;
        end
    end

    // State, bus and MEM/WB registers; reset abandons any outstanding access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            drop_q         <= 1'b0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            dmem_be_q      <= 4'b0000;
            wb_valid_q     <= 1'b0;
            wb_pc_q        <= '0;
            wb_rd_q        <= 5'd0;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= '0;
            wb_exc_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            drop_q         <= drop_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            dmem_be_q      <= dmem_be_d;
            wb_valid_q     <= wb_valid_d;
            wb_pc_q        <= wb_pc_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_data_q      <= wb_data_d;
            wb_exc_q       <= wb_exc_d;
        end
    end

    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign dmem_be      = dmem_be_q;
    assign wb_valid     = wb_valid_q;
    assign wb_pc        = wb_pc_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_data      = wb_data_q;
    assign wb_exc       = wb_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a transaction-level
// expectation model and a per-cycle output check.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_req;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        wb_exc;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_seen = 0;

    // expected outputs for the current cycle
    bit          exp_stall, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    bit          exp_v, exp_rw, exp_exc;
    logic [31:0] exp_pc, exp_data;
    logic [4:0]  exp_rd;
    // MEM/WB contents that the current cycle will register
    bit          nxt_v, nxt_rw, nxt_exc;
    logic [31:0] nxt_pc, nxt_data;
    logic [4:0]  nxt_rd;

    mem_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall_req(stall_req),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_data(wb_data), .wb_exc(wb_exc)
    );

    always #5 clk = ~clk;

    // Model: does this access fault (illegal width, read+write, or not size-aligned)?
    function automatic bit model_exc(input logic [31:0] a, input logic [2:0] f3,
                                     input bit rd_en, input bit wr_en);
        int size;
        size = 1 << f3[1:0];
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (rd_en && wr_en)
               || ((a % size) != 0);
    endfunction

    // Model: value a load returns from the word read at its address.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3,
                                               input logic [31:0] rdata);
        logic [31:0] w, v;
        w = rdata >> (8 * (a % 4));
        if (f3[1:0] == 2'd0) begin
            v = w & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else if (f3[1:0] == 2'd1) begin
            v = w & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // Model: store data as it must appear on the bus.
    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3[1:0] == 2'd0) return (sd & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 2'd1) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    // Model: byte enables covering the stored bytes.
    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] f3);
        int size;
        int mask;
        size = 1 << f3[1:0];
        mask = ((1 << size) - 1) << (a % 4);
        return mask[3:0];
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output that is meaningful this cycle against the expectation.
    task automatic checkOutput();
        check32("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
        check32("dmem_req", {31'd0, dmem_req}, {31'd0, exp_req});
        if (exp_req) begin
            check32("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we});
            check32("dmem_addr", dmem_addr, exp_addr);
            check32("dmem_be", {28'd0, dmem_be}, {28'd0, exp_be});
            if (exp_we) check32("dmem_wdata", dmem_wdata, exp_wdata);
        end
        check32("wb_valid", {31'd0, wb_valid}, {31'd0, exp_v});
        check32("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, exp_rw});
        check32("wb_exc", {31'd0, wb_exc}, {31'd0, exp_exc});
        if (exp_v) begin
            check32("wb_pc", wb_pc, exp_pc);
            check32("wb_rd", {27'd0, wb_rd}, {27'd0, exp_rd});
            check32("wb_data", wb_data, exp_data);
        end
        if (stall_req) stall_seen++;
    endtask

    task automatic set_nxt_bubble();
        nxt_v = 0; nxt_rw = 0; nxt_exc = 0; nxt_pc = '0; nxt_rd = '0; nxt_data = '0;
    endtask

    // Check mid-cycle, then advance one clock and expose the registered MEM/WB result.
    task automatic step();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        exp_v = nxt_v; exp_rw = nxt_rw; exp_exc = nxt_exc;
        exp_pc = nxt_pc; exp_rd = nxt_rd; exp_data = nxt_data;
        set_nxt_bubble();
    endtask

    // Drive one instruction through MEM; nwait = BUSY cycles before ack, flush_at = cycle index of flush (-1 none).
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] alu,
                                 input logic [31:0] sd, input logic [4:0] rd,
                                 input bit rw, input bit mr, input bit mw,
                                 input logic [2:0] f3, input logic [31:0] rdata,
                                 input int nwait, input int flush_at);
        bit access;
        bit dropped;
        ex_valid = 1; ex_pc = pc; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
        dmem_ack = 0; dmem_rdata = 32'hA5A5A5A5;
        flush = (flush_at == 0);
        access = mr || mw;
        exp_req = 0;
        exp_we = mw; exp_addr = alu & 32'hFFFFFFFC;
        exp_wdata = model_wdata(f3, sd);
        exp_be = mw ? model_be(alu, f3) : 4'b0000;
        if (flush_at == 0) begin
            exp_stall = 0;
            step();
        end else if (!access) begin
            exp_stall = 0;
            nxt_v = 1; nxt_pc = pc; nxt_rd = rd; nxt_rw = rw; nxt_data = alu; nxt_exc = 0;
            step();
        end else if (model_exc(alu, f3, mr, mw)) begin
            exp_stall = 0;
            nxt_v = 1; nxt_pc = pc; nxt_rd = rd; nxt_rw = 0; nxt_data = alu; nxt_exc = 1;
            step();
        end else begin
            exp_stall = 1;
            step();
            dropped = 0;
            for (int k = 1; k <= nwait; k++) begin
                flush = (flush_at == k);
                dropped = dropped || flush;
                exp_stall = 1; exp_req = 1;
                step();
            end
            flush = (flush_at == nwait + 1);
            dropped = dropped || flush;
            dmem_ack = 1; dmem_rdata = rdata;
            exp_stall = 0; exp_req = 1;
            if (!dropped) begin
                nxt_v = 1; nxt_pc = pc; nxt_rd = rd; nxt_rw = mr && rw; nxt_exc = 0;
                nxt_data = mr ? model_load(alu, f3, rdata) : alu;
            end
            step();
        end
        ex_valid = 0; flush = 0; dmem_ack = 0; ex_mem_read = 0; ex_mem_write = 0;
        exp_stall = 0; exp_req = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t required below 100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // model pins from hand-computed values
        check32("pin_lb", model_load(32'h1003, 3'b000, 32'h80FFFFFF), 32'hFFFFFF80);
        check32("pin_lbu", model_load(32'h1003, 3'b100, 32'h80FFFFFF), 32'h00000080);
        check32("pin_lh", model_load(32'h5002, 3'b001, 32'h80017FFF), 32'hFFFF8001);
        check32("pin_sh_wdata", model_wdata(3'b001, 32'hDEADBEEF), 32'hBEEFBEEF);
        check32("pin_sh_be", {28'd0, model_be(32'h2002, 3'b001)}, 32'h0000000C);
        check32("pin_sb_be", {28'd0, model_be(32'h6001, 3'b000)}, 32'h00000002);
        check32("pin_lw_exc", {31'd0, model_exc(32'h3001, 3'b010, 1, 0)}, 32'd1);

        // reset with an aligned load presented: stall must stay low
        rst = 1; flush = 0; dmem_ack = 0; dmem_rdata = '0;
        ex_valid = 1; ex_pc = 32'h80; ex_alu_result = 32'h1000; ex_store_data = '0;
        ex_rd = 5'd1; ex_reg_write = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
        exp_stall = 0; exp_req = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
        exp_v = 0; exp_rw = 0; exp_exc = 0; exp_pc = '0; exp_rd = '0; exp_data = '0;
        set_nxt_bubble();
        @(negedge clk);
        checkOutput();
        check32("reset_wb_pc", wb_pc, 32'd0);
        check32("reset_wb_data", wb_data, 32'd0);
        @(posedge clk); #1;
        rst = 0; ex_valid = 0; ex_mem_read = 0;
        step();

        // ADD: no stall, result next cycle
        stall_seen = 0;
        applyStimulus(32'h100, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 3'b000, 32'h0, 0, -1);
        step();
        check32("add_stall_cycles", stall_seen, 0);
        check32("add_wb_data_literal", wb_data, 32'h00001234);

        // LB / LBU with two wait cycles: stall high for three cycles
        stall_seen = 0;
        applyStimulus(32'h104, 32'h1003, 32'h0, 5'd6, 1, 1, 0, 3'b000, 32'h80FFFFFF, 2, -1);
        check32("lb_stall_cycles", stall_seen, 3);
        applyStimulus(32'h108, 32'h1003, 32'h0, 5'd7, 1, 1, 0, 3'b100, 32'h80FFFFFF, 2, -1);
        // SH, ack in first BUSY cycle
        applyStimulus(32'h10C, 32'h2002, 32'hDEADBEEF, 5'd0, 0, 0, 1, 3'b001, 32'h0, 0, -1);
        // misaligned LW: exception, no request
        applyStimulus(32'h110, 32'h3001, 32'h0, 5'd8, 1, 1, 0, 3'b010, 32'h0, 0, -1);
        // LW flushed in first BUSY cycle, ack three cycles later
        applyStimulus(32'h114, 32'h4000, 32'h0, 5'd9, 1, 1, 0, 3'b010, 32'h11223344, 3, 1);
        // halfword loads, signed and unsigned
        applyStimulus(32'h118, 32'h5002, 32'h0, 5'd10, 1, 1, 0, 3'b001, 32'h80017FFF, 1, -1);
        applyStimulus(32'h11C, 32'h5002, 32'h0, 5'd11, 1, 1, 0, 3'b101, 32'h80017FFF, 0, -1);
        // SB and SW
        applyStimulus(32'h120, 32'h6001, 32'h12345678, 5'd0, 0, 0, 1, 3'b000, 32'h0, 1, -1);
        applyStimulus(32'h124, 32'h6004, 32'hCAFEF00D, 5'd0, 0, 0, 1, 3'b010, 32'h0, 0, -1);
        // aligned LW and LB at lane 2
        applyStimulus(32'h128, 32'h7008, 32'h0, 5'd12, 1, 1, 0, 3'b010, 32'h89ABCDEF, 0, -1);
        applyStimulus(32'h12C, 32'h700A, 32'h0, 5'd13, 1, 1, 0, 3'b000, 32'h0055AA00, 0, -1);
        // illegal width, read+write, misaligned SH
        applyStimulus(32'h130, 32'h8000, 32'h0, 5'd14, 1, 1, 0, 3'b011, 32'h0, 0, -1);
        applyStimulus(32'h134, 32'h8000, 32'h0, 5'd15, 1, 1, 1, 3'b010, 32'h0, 0, -1);
        applyStimulus(32'h138, 32'h2001, 32'h55, 5'd0, 0, 0, 1, 3'b001, 32'h0, 0, -1);
        // flush in IDLE on an ALU op and on a load; flush on the ack cycle
        applyStimulus(32'h13C, 32'h9999, 32'h0, 5'd16, 1, 0, 0, 3'b000, 32'h0, 0, 0);
        applyStimulus(32'h140, 32'h9000, 32'h0, 5'd17, 1, 1, 0, 3'b010, 32'h0, 0, 0);
        applyStimulus(32'h144, 32'h9004, 32'h0, 5'd18, 1, 1, 0, 3'b010, 32'h77777777, 1, 2);

        // reset while BUSY
        ex_valid = 1; ex_pc = 32'h148; ex_alu_result = 32'hA000; ex_rd = 5'd19;
        ex_reg_write = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
        exp_stall = 1; exp_req = 0; exp_we = 0; exp_addr = 32'hA000; exp_be = 4'b0000;
        step();
        exp_stall = 1; exp_req = 1;
        step();
        rst = 1;
        exp_stall = 0; exp_req = 0; exp_v = 0; exp_rw = 0; exp_exc = 0;
        set_nxt_bubble();
        @(negedge clk);
        checkOutput();
        check32("rst_busy_wb_pc", wb_pc, 32'd0);
        check32("rst_busy_wb_rd", {27'd0, wb_rd}, 32'd0);
        check32("rst_busy_wb_data", wb_data, 32'd0);
        @(posedge clk); #1;
        rst = 0; ex_valid = 0; ex_mem_read = 0; dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
        step();
        dmem_ack = 0;
        step();
        applyStimulus(32'h14C, 32'h4321, 32'h0, 5'd20, 1, 0, 0, 3'b000, 32'h0, 0, -1);
        step();
        check32("post_rst_add_literal", wb_data, 32'h00004321);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
